// File: rtl/spike_generator_array_if.sv
// Programming and tag/count output channels of the spike generator bank.
// slave is the generator bank's side, master is the programming source / tag consumer.
interface spike_generator_array_if #(
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11,
    parameter int Nct     = 9
);
    logic [Ngens-1:0]   prog_gen_idx;
    logic [Nperiod-1:0] prog_period;
    logic [Nperiod-1:0] prog_ticks;
    logic [Ntag-1:0]    prog_tag;
    logic               prog_v;
    logic               prog_a;

    logic [Ntag-1:0]    out_tag;
    logic [Nct-1:0]     out_ct;
    logic               out_v;
    logic               out_a;

    modport master (
        output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v,
        input  prog_a,
        input  out_tag, out_ct, out_v,
        output out_a
    );

    modport slave (
        input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v,
        output prog_a,
        output out_tag, out_ct, out_v,
        input  out_a
    );
endinterface

// File: rtl/spike_generator_array.sv
// Bank of 2**Ngens periodic spike generators scanned once per time-unit tick.
// Optional SPIKE_GEN_OVERRUN_CNT_EN adds a saturating count of dropped time-unit pulses.
//
// state | meaning
// IDLE  | accepts programming words, waits for a tick or a pending tick
// SCAN  | evaluates slot idx, one slot per cycle
// EMIT  | holds a tag/count word until the consumer accepts it
module spike_generator_array #(
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11,
    parameter int Nct     = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  time_unit_pulse,
    input  logic [Ngens-1:0]      gens_used,
    input  logic [2**Ngens-1:0]   gens_en,
    spike_generator_array_if.slave bus
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
    ,
    output logic [15:0]           overrun_count
`endif
);
    localparam int Nslots = 2**Ngens;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0]         state;
    logic               pending;
    logic [Ngens-1:0]   idx;

    logic [Nperiod-1:0] period_mem [Nslots];
    logic [Nperiod-1:0] ticks_mem  [Nslots];
    logic [Ntag-1:0]    tag_mem    [Nslots];

    logic [Ntag-1:0]    out_tag_q;
    logic [Nct-1:0]     out_ct_q;
    logic               out_v_q;

    logic [Nperiod-1:0] cur_period;
    logic [Nperiod-1:0] cur_ticks;
    logic [Ntag-1:0]    cur_tag;
    logic               cur_active;
    logic               cur_fire;
    logic               last_idx;
    logic               prog_hs;

    assign cur_period = period_mem[idx];
    assign cur_ticks  = ticks_mem[idx];
    assign cur_tag    = tag_mem[idx];
    assign cur_active = gens_en[idx] && (cur_period != '0);
    // ticks of 0 or 1 both fire so a freshly programmed ticks=0 fires on the next scan
    assign cur_fire   = cur_active && (cur_ticks <= Nperiod'(1));
    assign last_idx   = (idx == gens_used);

    assign bus.prog_a  = (state == IDLE) && !pending;
    assign prog_hs     = bus.prog_v && bus.prog_a;
    assign bus.out_tag = out_tag_q;
    assign bus.out_ct  = out_ct_q;
    assign bus.out_v   = out_v_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            idx       <= '0;
            out_v_q   <= 1'b0;
            out_tag_q <= '0;
            out_ct_q  <= '0;
            for (int i = 0; i < Nslots; i++) begin
                period_mem[i] <= '0;
                ticks_mem[i]  <= '0;
                tag_mem[i]    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (prog_hs) begin
                        period_mem[bus.prog_gen_idx] <= bus.prog_period;
                        ticks_mem[bus.prog_gen_idx]  <= bus.prog_ticks;
                        tag_mem[bus.prog_gen_idx]    <= bus.prog_tag;
                    end
                    if (pending || time_unit_pulse) begin
                        state   <= SCAN;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                SCAN: begin
                    if (time_unit_pulse) pending <= 1'b1;
                    if (cur_fire) begin
                        ticks_mem[idx] <= cur_period;
                        out_v_q        <= 1'b1;
                        out_tag_q      <= cur_tag;
                        out_ct_q       <= Nct'(1);
                        state          <= EMIT;
                    end else begin
                        if (cur_active) ticks_mem[idx] <= cur_ticks - 1'b1;
                        if (last_idx) state <= IDLE;
                        else          idx   <= idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (time_unit_pulse) pending <= 1'b1;
                    if (bus.out_a) begin
                        out_v_q <= 1'b0;
                        if (last_idx) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPIKE_GEN_OVERRUN_CNT_EN
    // a pulse seen while one is already pending is lost, wherever the FSM is
    logic pulse_drop;
    assign pulse_drop = time_unit_pulse && pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_count <= '0;
        end else if (pulse_drop && (overrun_count != 16'hFFFF)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_spike_generator_array.sv
// Self-checking bench for spike_generator_array with a per-tick slot model.
// Honors SPIKE_GEN_OVERRUN_CNT_EN for the overrun counter port.
module tb_spike_generator_array;
    localparam int NG = 8;
    localparam int NP = 16;
    localparam int NT = 11;
    localparam int NC = 9;
    localparam int NS = 2**NG;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          time_unit_pulse;
    logic [NG-1:0] gens_used;
    logic [NS-1:0] gens_en;
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
    logic [15:0]   overrun_count;
`endif

    spike_generator_array_if #(.Ngens(NG), .Nperiod(NP), .Ntag(NT), .Nct(NC)) bus ();

    spike_generator_array #(.Ngens(NG), .Nperiod(NP), .Ntag(NT), .Nct(NC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .time_unit_pulse (time_unit_pulse),
        .gens_used       (gens_used),
        .gens_en         (gens_en),
        .bus             (bus.slave)
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
        ,
        .overrun_count   (overrun_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          mon_en = 1'b0;
    logic [NT-1:0] got_tag [$];
    logic [NC-1:0] got_ct  [$];
    logic [NT-1:0] exp_tag [$];

    int m_period [NS];
    int m_ticks  [NS];
    int m_tag    [NS];

    // a word is transferred on the edge following a negedge that sees out_v && out_a
    always @(negedge clk) begin
        if (mon_en && bus.out_v && bus.out_a) begin
            got_tag.push_back(bus.out_tag);
            got_ct.push_back(bus.out_ct);
        end
    end

    function automatic void model_scan();
        for (int i = 0; i <= int'(gens_used); i++) begin
            if (gens_en[i] && m_period[i] != 0) begin
                if (m_ticks[i] <= 1) begin
                    m_ticks[i] = m_period[i];
                    exp_tag.push_back(NT'(m_tag[i]));
                end else begin
                    m_ticks[i] = m_ticks[i] - 1;
                end
            end
        end
    endfunction

    task automatic apply_reset();
        reset_n          = 1'b0;
        time_unit_pulse  = 1'b0;
        gens_used        = '0;
        gens_en          = '0;
        bus.prog_v       = 1'b0;
        bus.prog_gen_idx = '0;
        bus.prog_period  = '0;
        bus.prog_ticks   = '0;
        bus.prog_tag     = '0;
        bus.out_a        = 1'b1;
        for (int i = 0; i < NS; i++) begin
            m_period[i] = 0;
            m_ticks[i]  = 0;
            m_tag[i]    = 0;
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic program_slot(input int idx, input int per, input int tk, input int tg);
        bit ok = 0;
        bus.prog_gen_idx = NG'(idx);
        bus.prog_period  = NP'(per);
        bus.prog_ticks   = NP'(tk);
        bus.prog_tag     = NT'(tg);
        bus.prog_v       = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.prog_a) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1 bus.prog_v = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prog_accept slot %0d: prog_a never seen high, required 1", idx);
        end
        m_period[idx] = per;
        m_ticks[idx]  = tk;
        m_tag[idx]    = tg;
    endtask

    task automatic pulse();
        time_unit_pulse = 1'b1;
        @(posedge clk);
        #1 time_unit_pulse = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_bp);
        bit seen = 0;
        for (int k = 0; k < 3000; k++) begin
            if (rand_bp) bus.out_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            seen = bus.prog_a;
            @(posedge clk);
            #1;
            if (seen) break;
        end
        bus.out_a = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL idle_timeout: prog_a=0 after 3000 cycles, required 1");
        end
    endtask

    task automatic wait_outv(input string nm);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_v) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: out_v=0 after 20 cycles, required 1", nm);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 4;
        if (bus.out_v !== 1'b0) begin errors++; $display("FAIL rst_out_v: got %b want 0", bus.out_v); end
        if (bus.out_tag !== '0) begin errors++; $display("FAIL rst_out_tag: got %h want 0", bus.out_tag); end
        if (bus.out_ct !== '0) begin errors++; $display("FAIL rst_out_ct: got %h want 0", bus.out_ct); end
        if (bus.prog_a !== 1'b1) begin errors++; $display("FAIL rst_prog_a: got %b want 1", bus.prog_a); end
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
        checks++;
        if (overrun_count !== 16'd0) begin errors++; $display("FAIL rst_overrun: got %0d want 0", overrun_count); end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_periodic();
        gens_en = '0;
        gens_en[3] = 1'b1;
        gens_used = NG'(3);
        bus.out_a = 1'b1;
        program_slot(3, 4, 2, 'h155);
        mon_en = 1'b1;
        for (int p = 1; p <= 10; p++) begin
            int n_exp;
            n_exp = (p == 2 || p == 6 || p == 10) ? 1 : 0;
            got_tag.delete(); got_ct.delete();
            pulse();
            wait_idle(0);
            checks++;
            if (got_tag.size() != n_exp) begin
                errors++;
                $display("FAIL periodic_count pulse %0d: got %0d words want %0d", p, got_tag.size(), n_exp);
            end else if (n_exp == 1) begin
                checks++;
                if (got_tag[0] !== 11'h155 || got_ct[0] !== 9'd1) begin
                    errors++;
                    $display("FAIL periodic_word pulse %0d: got tag %h ct %0d want 155 ct 1", p, got_tag[0], got_ct[0]);
                end
            end
        end
    endtask

    task automatic test_order_latency();
        gens_en = '0;
        gens_en[1:0] = 2'b11;
        gens_used = NG'(1);
        program_slot(0, 1, 1, 'h001);
        program_slot(1, 1, 1, 'h002);
        for (int r = 0; r < 3; r++) begin
            got_tag.delete(); got_ct.delete();
            pulse();
            @(negedge clk);
            checks++;
            if (bus.out_v !== 1'b0) begin errors++; $display("FAIL latency_t1 rep %0d: out_v %b want 0", r, bus.out_v); end
            @(negedge clk);
            checks++;
            if (bus.out_v !== 1'b1) begin errors++; $display("FAIL latency_t2 rep %0d: out_v %b want 1", r, bus.out_v); end
            @(posedge clk);
            #1;
            wait_idle(0);
            checks++;
            if (got_tag.size() != 2) begin
                errors++;
                $display("FAIL order_count rep %0d: got %0d words want 2", r, got_tag.size());
            end else begin
                checks++;
                if (got_tag[0] !== 11'h001 || got_tag[1] !== 11'h002 || got_ct[0] !== 9'd1 || got_ct[1] !== 9'd1) begin
                    errors++;
                    $display("FAIL order_words rep %0d: got %h/%0d %h/%0d want 001/1 002/1",
                             r, got_tag[0], got_ct[0], got_tag[1], got_ct[1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit prog_a_hi = 0;
        int hit = -1;
        gens_en = '0;
        gens_en[0] = 1'b1;
        gens_used = '0;
        got_tag.delete(); got_ct.delete();
        bus.out_a = 1'b0;
        pulse();
        wait_outv("stall_outv");
        @(posedge clk);
        #1;
        for (int c = 0; c < 20; c++) begin
            time_unit_pulse = (c == 10);
            @(negedge clk);
            checks++;
            if (bus.out_v !== 1'b1 || bus.out_tag !== 11'h001 || bus.prog_a !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc %0d: out_v %b tag %h prog_a %b want 1 001 0",
                         c, bus.out_v, bus.out_tag, bus.prog_a);
            end
            @(posedge clk);
            #1;
        end
        time_unit_pulse = 1'b0;
        bus.out_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (got_tag.size() >= 2) begin
                hit = k;
                break;
            end
            if (bus.prog_a) prog_a_hi = 1;
        end
        checks += 2;
        if (hit != 3) begin errors++; $display("FAIL stall_rescan_latency: second word at %0d want 3", hit); end
        if (prog_a_hi) begin errors++; $display("FAIL stall_pending_prog_a: prog_a rose before rescan, want 0"); end
        @(posedge clk);
        #1;
        wait_idle(0);
        checks++;
        if (got_tag.size() != 2) begin errors++; $display("FAIL stall_total: got %0d words want 2", got_tag.size()); end
    endtask

    task automatic test_overrun();
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
        logic [15:0] base;
`endif
        got_tag.delete(); got_ct.delete();
        bus.out_a = 1'b0;
        pulse();
        wait_outv("overrun_outv");
        @(posedge clk);
        #1;
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
        base = overrun_count;
`endif
        pulse();
        pulse();
        repeat (3) @(posedge clk);
        #1;
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
        checks++;
        if (overrun_count !== base + 16'd1) begin
            errors++;
            $display("FAIL overrun_count: got %0d want %0d", overrun_count, base + 16'd1);
        end
`endif
        bus.out_a = 1'b1;
        wait_idle(0);
        checks++;
        if (got_tag.size() != 2) begin errors++; $display("FAIL overrun_words: got %0d words want 2", got_tag.size()); end
    endtask

    task automatic test_disable();
        int fire_at [5] = '{0, 1, 0, 0, 1};
        gens_en = '0;
        gens_used = NG'(5);
        program_slot(5, 3, 2, 'h0AA);
        program_slot(6, 0, 1, 'h0BB);
        gens_en[6] = 1'b1;
        got_tag.delete(); got_ct.delete();
        repeat (3) begin
            pulse();
            wait_idle(0);
        end
        checks++;
        if (got_tag.size() != 0) begin errors++; $display("FAIL disabled_quiet: got %0d words want 0", got_tag.size()); end
        gens_en[5] = 1'b1;
        for (int p = 0; p < 5; p++) begin
            got_tag.delete(); got_ct.delete();
            pulse();
            wait_idle(0);
            checks++;
            if (got_tag.size() != fire_at[p] || (fire_at[p] == 1 && got_tag[0] !== 11'h0AA)) begin
                errors++;
                $display("FAIL reenable pulse %0d: got %0d words want %0d of tag 0aa", p, got_tag.size(), fire_at[p]);
            end
        end
    endtask

    task automatic test_boundary();
        gens_en = '0;
        gens_en[NS-1] = 1'b1;
        gens_used = NG'(NS - 1);
        program_slot(NS - 1, 1, 0, 'h7FF);
        got_tag.delete(); got_ct.delete();
        pulse();
        wait_idle(0);
        checks++;
        if (got_tag.size() != 1 || got_tag[0] !== 11'h7FF) begin
            errors++;
            $display("FAIL last_slot: got %0d words want 1 of tag 7ff", got_tag.size());
        end
        gens_used = NG'(NS - 2);
        got_tag.delete(); got_ct.delete();
        pulse();
        wait_idle(0);
        checks++;
        if (got_tag.size() != 0) begin errors++; $display("FAIL gens_used_limit: got %0d words want 0", got_tag.size()); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int it = 0; it < 6; it++) begin
            gens_used = NG'($urandom_range(0, 15));
            gens_en = '0;
            gens_en[15:0] = 16'($urandom);
            for (int s = 0; s < 5; s++)
                program_slot($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 5),
                             $urandom_range(0, 2047));
            for (int p = 0; p < 6; p++) begin
                if (p == 3) gens_en[15:0] = 16'($urandom);
                got_tag.delete(); got_ct.delete(); exp_tag.delete();
                model_scan();
                pulse();
                wait_idle(1);
                checks++;
                if (got_tag.size() != exp_tag.size()) begin
                    errors++;
                    $display("FAIL rand_count it %0d p %0d: got %0d words want %0d", it, p, got_tag.size(), exp_tag.size());
                end else begin
                    for (int w = 0; w < exp_tag.size(); w++) begin
                        checks++;
                        if (got_tag[w] !== exp_tag[w] || got_ct[w] !== 9'd1) begin
                            errors++;
                            $display("FAIL rand_word it %0d p %0d w %0d: got %h/%0d want %h/1",
                                     it, p, w, got_tag[w], got_ct[w], exp_tag[w]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        gens_en = '0;
        gens_en[0] = 1'b1;
        gens_used = '0;
        program_slot(0, 1, 1, 'h003);
        bus.out_a = 1'b0;
        pulse();
        wait_outv("rstmid_outv");
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_v !== 1'b0 || bus.out_tag !== '0) begin
            errors++;
            $display("FAIL async_reset: out_v %b tag %h want 0 000", bus.out_v, bus.out_tag);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.out_a = 1'b1;
        got_tag.delete(); got_ct.delete();
        repeat (2) begin
            pulse();
            wait_idle(0);
        end
        checks++;
        if (got_tag.size() != 0) begin errors++; $display("FAIL post_reset_quiet: got %0d words want 0", got_tag.size()); end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_periodic();
        test_order_latency();
        test_stall();
        test_overrun();
        test_disable();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_generator_array.md
Name: spike_generator_array

Overview:
Bank of up to 2**Ngens periodic spike generators. Consumes generator programming words and the generator configuration registers, and is advanced by a one-cycle time-unit tick from the time manager. Emits one tag/count word per generator firing on a tag/count output channel toward the tag router. Sits between the PC programming path and the downstream tag/count consumer.

Parameters:
- Ngens, 8: generator index width; 2**Ngens generator slots.
- Nperiod, 16: period and tick counter width, in time units.
- Ntag, 11: output tag width.
- Nct, 9: output count width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- time_unit_pulse  in  1  one-cycle strobe, once per wall-clock time unit
- gens_used  in  Ngens  highest generator index scanned (inclusive)
- gens_en  in  2**Ngens  per-generator enable
- prog_gen_idx  in  Ngens  generator slot being programmed
- prog_period  in  Nperiod  reload period
- prog_ticks  in  Nperiod  initial tick count
- prog_tag  in  Ntag  tag emitted on firing
- prog_v  in  1  programming word valid
- prog_a  out  1  programming word accepted
- out_tag  out  Ntag  emitted tag
- out_ct  out  Nct  emitted count
- out_v  out  1  output valid
- out_a  in  1  output accept

Behaviour:
- Handshakes: a transfer occurs on a rising edge with v&&a. Once out_v is asserted, out_v, out_tag and out_ct hold until accepted.
- Storage: per slot {period, ticks, tag}. Flops or RAM with same-cycle read.
- Reset: all slots zero; out_v=0, out_tag=0, out_ct=0; state IDLE; pending=0; idx=0.
- FSM states IDLE, SCAN, EMIT:
  - IDLE: prog_a=1 only when pending=0. On a prog handshake, write all three fields of slot prog_gen_idx.
  - IDLE: if pending=1 or time_unit_pulse=1, go to SCAN next cycle with idx=0 and clear pending. A prog write in the same cycle completes first.
  - SCAN, one slot per cycle: the slot is active iff gens_en[idx]=1 and period!=0.
    - Active with ticks<=1: reload ticks=period, set out_v=1, out_tag=tag, out_ct=1 next cycle, go to EMIT.
    - Active with ticks>1: ticks-=1.
    - Inactive: slot unchanged.
    - Non-firing: if idx==gens_used go to IDLE, else idx+=1 and stay in SCAN.
  - EMIT: on out_a, out_v<=0. If idx==gens_used go to IDLE, else idx+=1 and go to SCAN.
  - prog_a=0 in SCAN and EMIT.
- Latency: pulse in IDLE at cycle t → slot 0 evaluated at t+1 → out_v for slot 0 at t+2.
- Time pulse while not in IDLE: sets pending, consumed at the next IDLE.
  - A pulse that arrives while pending=1 is dropped (overrun).
  - A pulse coincident with the scan finishing (last-idx cycle) also sets pending.
- Period = 1 fires every time unit.
- Programming ticks=0 fires on the next scan.
- Changing gens_en or gens_used mid-scan takes effect from the current idx onward.
- gens_used is compared to idx at full Ngens width; 2**Ngens-1 scans all slots.
- Reset asserted mid-scan or mid-EMIT: immediate return to reset values. Any output word being held is lost.

Optional Feature:
- Macro SPIKE_GEN_OVERRUN_CNT_EN.
- Defined: adds output port overrun_count (16 bits), reset to 0. Increments, saturating at 16'hFFFF, each time a time_unit_pulse is dropped because pending=1.
- Undefined: no port, no counter; dropped pulses are silent.

Test Plan:
- Program slot 3: period=4, ticks=2, tag=0x155; gens_en[3]=1, gens_used=3, out_a=1; apply 10 pulses → tag 0x155 with ct=1 after pulses 2, 6 and 10 only.
- Slot 0 period=1, slot 1 period=1 (tags 0x001, 0x002), out_a=1 → two words per pulse, order 0x001 then 0x002. First out_v exactly 2 cycles after the pulse.
- Hold out_a=0 for 20 cycles while slot 0 fires → out_v and out_tag stable, prog_a=0 throughout; a pulse during the stall sets pending and a rescan starts immediately after completion.
- Two pulses during a stalled EMIT → second is dropped. With SPIKE_GEN_OVERRUN_CNT_EN, overrun_count=1.
- gens_en[5]=0 or period=0 on a programmed slot → no output, ticks unchanged. Re-enabling resumes from the stored ticks.
- Assert reset_n=0 while out_v=1 → out_v falls asynchronously. After release, no output until slots are reprogrammed.
